// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared owner tags and size encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam logic       OWNER_I       = 1'b0;
  localparam logic       OWNER_D       = 1'b1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
endpackage

// File: rtl/mem_port_arbiter_resp_owner_pipe.sv
// rtl/mem_port_arbiter_resp_owner_pipe.sv - valid/owner shift register tracking in-flight reads
module mem_port_arbiter_resp_owner_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_owner,
  input  logic flush_i,
  output logic out_valid,
  output logic out_owner
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] owner_q;

  // Stage 0 is never flushed so a fetch accepted in the flush cycle survives;
  // the last stage shifts out on its own, so only inner transfers are gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= push;
      owner_q[0] <= push_owner;
      for (int k = 1; k < RD_LAT; k++) begin
        valid_q[k] <= valid_q[k-1] && !(flush_i && owner_q[k-1] == OWNER_I);
        owner_q[k] <= owner_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_owner = owner_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between fetch (I) and load/store (D)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;
  logic       i_pri;
  logic       push;
  logic       push_owner;
  logic       pipe_valid;
  logic       pipe_owner;

  assign i_pri = (starve_cnt == MAX_CNT);

  // Data side wins contention unless fetch has been starved for MAX_WAIT cycles.
  always_comb begin
    d_gnt     = !reset && d_req && !(i_req && i_pri);
    i_gnt     = !reset && i_req && !(d_req && !i_pri);
    mem_en    = d_gnt || i_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = 2'b00;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_size  = d_size;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
      mem_size  = MEM_SIZE_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (i_req && i_gnt) begin
      starve_cnt <= '0;
    end else if (i_req && !i_pri) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign push       = i_gnt || (d_gnt && !d_we);
  assign push_owner = d_gnt ? OWNER_D : OWNER_I;

  mem_port_arbiter_resp_owner_pipe #(
    .RD_LAT(RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_owner(push_owner),
    .flush_i   (i_flush),
    .out_valid (pipe_valid),
    .out_owner (pipe_owner)
  );

  // Responses are gated during reset so a read accepted just before reset never surfaces.
  assign i_rvalid = !reset && !i_flush && pipe_valid && (pipe_owner == OWNER_I);
  assign d_rvalid = !reset && pipe_valid && (pipe_owner == OWNER_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        i_flush = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = 2'b00;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_flush(i_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t iq[$];
  resp_t dq[$];
  int    m_starve = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: fixed content per address, read data RD_LAT cycles after the access.
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? memf(mem_addr) : $urandom;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: predicts grants and memory drive, pushes expected responses.
  always @(negedge clk) begin
    logic ei, ed;
    if (reset) begin
      ei = 1'b0;
      ed = 1'b0;
    end else begin
      ed = d_req && !(i_req && m_starve == MAX_WAIT);
      ei = i_req && !ed;
    end
    chk("i_gnt", i_gnt, ei);
    chk("d_gnt", d_gnt, ed);
    chk("mem_en", mem_en, ei || ed);
    chk("mem_we", mem_we, ed && d_we);
    if (ed) begin
      chk("mem_addr_d", mem_addr, d_addr);
      chk("mem_size_d", mem_size, d_size);
      if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end else if (ei) begin
      chk("mem_addr_i", mem_addr, i_addr);
      chk("mem_size_i", mem_size, 2'b10);
    end
    if (reset) begin
      iq.delete();
      dq.delete();
      m_starve = 0;
    end else begin
      if (i_flush) iq.delete();
      if (ei) iq.push_back('{cyc + RD_LAT, memf(i_addr)});
      if (ed && !d_we) dq.push_back('{cyc + RD_LAT, memf(d_addr)});
      if (i_req && ei) m_starve = 0;
      else if (i_req && m_starve < MAX_WAIT) m_starve++;
    end
  end

  // Monitor: pops expected responses whenever the DUT presents one, or when one is due.
  always begin
    @(negedge clk);
    #1;
    if (i_rvalid) begin
      if (iq.size() == 0 || iq[0].due != cyc) chk("i_rvalid_extra", i_rvalid, 1'b0);
      else begin
        chk("i_rdata", i_rdata, iq[0].data);
        void'(iq.pop_front());
      end
    end else if (iq.size() != 0 && iq[0].due <= cyc) begin
      chk("i_rvalid_missing", i_rvalid, 1'b1);
      void'(iq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0 || dq[0].due != cyc) chk("d_rvalid_extra", d_rvalid, 1'b0);
      else begin
        chk("d_rdata", d_rdata, dq[0].data);
        void'(dq.pop_front());
      end
    end else if (dq.size() != 0 && dq[0].due <= cyc) begin
      chk("d_rvalid_missing", d_rvalid, 1'b1);
      void'(dq.pop_front());
    end
  end

  task automatic step_rand(input int p_req, input int p_flush, input int p_we);
    logic ia, da;
    @(negedge clk);
    ia = i_req && i_gnt;
    da = d_req && d_gnt;
    @(posedge clk);
    #1;
    if (!i_req || ia) begin
      i_req  = ($urandom_range(99) < p_req);
      i_addr = {22'd0, 8'($urandom_range(255)), 2'b00};
    end
    if (!d_req || da) begin
      d_req   = ($urandom_range(99) < p_req);
      d_we    = ($urandom_range(99) < p_we);
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_size  = 2'($urandom_range(2));
    end
    i_flush = ($urandom_range(99) < p_flush);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_i_rvalid", i_rvalid, 1'b0);
    chk("reset_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h40;
    @(posedge clk);
    #1;
    d_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    i_req   = 1'b1;
    i_addr  = 32'h100;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h4;
    d_wdata = 32'd42;
    d_size  = 2'b10;
    repeat (24) step_rand(100, 0, 0);
    repeat (300) step_rand(70, 20, 30);
    repeat (2000) step_rand($urandom_range(20, 100), $urandom_range(0, 10), 30);
    @(posedge clk);
    #1;
    i_req   = 1'b1;
    d_req   = 1'b1;
    reset   = 1'b1;
    i_flush = 1'b0;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b0;
    repeat (300) step_rand(60, 8, 30);
    @(posedge clk);
    #1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    i_flush = 1'b0;
    repeat (RD_LAT + 3) @(posedge clk);
    #2;
    chk("drain_i", iq.size(), 0);
    chk("drain_d", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous main-memory port between instruction fetch (port I) and load/store (port D).
- Needed once the core fetches and accesses data through one SRAM port instead of the dual-port simulation memory.
- Same-cycle request/grant arbitration: data side has priority, with a starvation guard for fetch.
- Tracks in-flight reads through a RD_LAT-deep owner pipeline, routes read data back to the owning port, and supports cancelling in-flight fetches on redirect.

Parameters:
- ADDR_W, 32, address width (ADDR_LEN).
- DATA_W, 32, data width (DATA_LEN).
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets priority; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- i_flush  in  1  cancel all in-flight fetch reads
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  2  access size (same encoding as dmem_size[1:0])
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_size  out  2  memory access size
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after a read with mem_en=1, mem_we=0

Behaviour:
- Clock and reset: clk, reset synchronous active-high.
- Reset values: owner pipeline cleared; starve_cnt=0; i_rvalid=d_rvalid=0.
- Grant outputs: i_gnt, d_gnt and the mem_* outputs are combinational from the request inputs and from state. All are 0 while reset is high.
- Handshake:
  - A request is accepted when req&&gnt.
  - The requester holds req and all request fields stable until accepted.
  - gnt never asserts without req.
  - At most one gnt per cycle.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, D wins unless starve_cnt==MAX_WAIT, in which case I wins.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, on cycles with i_req && !i_gnt.
  - Clears on any cycle with i_req && i_gnt.
  - Holds when i_req=0.
- Memory drive on accept:
  - mem_en=1; mem_addr/mem_size/mem_wdata come from the granted port.
  - mem_we = d_we for D, 0 for I; mem_size for I is word (2'b10).
  - With no accept: mem_en=0, mem_we=0, other mem_* outputs don't-care (driven 0).
- Owner pipeline:
  - RD_LAT stages, each holding {valid, owner}.
  - Stage 0 is loaded on an accepted read (I, or D with d_we=0).
  - Stores load an invalid entry and never produce rvalid.
  - Output stage RD_LAT-1 drives:
    - i_rvalid = valid && owner==I;
    - d_rvalid = valid && owner==D;
    - i_rdata = d_rdata = mem_rdata (unqualified).
- Latency: rvalid rises exactly RD_LAT cycles after the accepting clock edge. Throughput is one access per cycle; back-to-back responses come out in grant order.
- Flush:
  - On i_flush=1, every valid stage with owner==I is invalidated at the clock edge.
  - The I response visible in the same cycle is also suppressed: i_rvalid is gated by !i_flush.
  - A fetch accepted in the flush cycle is NOT cancelled.
  - D entries are unaffected by flush.
- Reset mid-operation: all in-flight reads are dropped; no rvalid for them after reset deasserts.
- No buffering: the arbiter never queues requests; a denied port simply retries.

Decomposition:
- Shared package/header (constants.vh): OWNER_I=1'b0, OWNER_D=1'b1, MEM_SIZE_WORD=2'b10. ADDR_LEN/DATA_LEN are reused.
- Sub-module resp_owner_pipe(RD_LAT):
  - Holds the valid/owner shift register.
  - Inputs: push, push_owner, flush_i.
  - Outputs: out_valid, out_owner.
  - The arbiter top holds the grant logic, starve_cnt and the mem_* muxing.

Test Plan:
- Single I read, RD_LAT=1: i_req=1, i_addr=0x100; mem returns 0xDEADBEEF → i_gnt=1 in cycle 0, i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 1, d_rvalid=0.
- Contention with MAX_WAIT=4: i_req and d_req held high continuously (D issues loads back-to-back) → D granted cycles 0-3, I granted cycle 4, starve_cnt back to 0 in cycle 5, D granted again in cycle 5.
- Store produces no response: d_req=1, d_we=1, d_addr=0x4, d_wdata=42 → mem_en=mem_we=1 with mem_wdata=42 in the grant cycle; d_rvalid stays 0 for the following 5 cycles.
- Flush with RD_LAT=3: I reads at cycles 0 and 1, D load at cycle 2, i_flush=1 at cycle 2 → no i_rvalid at cycles 3 and 4; d_rvalid=1 at cycle 5.
- Flush coincident with a new fetch: i_flush=1 and an I accept in the same cycle → that fetch's i_rvalid arrives RD_LAT cycles later.
- Reset mid-flight: D load accepted, reset asserted the next cycle for 2 cycles → d_rvalid never asserts; all gnt=0 during reset; starve_cnt=0 afterwards.
